mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported unified memory between the instruction-fetch stage and the memory stage of the 5-stage RISC-V pipeline. It grants one outstanding transaction at a time and registers the chosen request onto the memory bus. It returns read data and a one-cycle completion pulse to the owner, and drives per-stage stall signals for the pipeline control logic. Data accesses normally win over fetch, and a streak guard bounds fetch starvation.

## Interface
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width; `DATA_W/8` strobe bits
- `MAX_STREAK`, 4: maximum consecutive data grants while fetch waits (≥1)

- `clk` input 1: clock, all state on rising edge
- `rst` input 1: reset; asynchronous, active-high
- `if_req` input 1: fetch request, held with `if_addr` until `if_valid`
- `if_addr` input ADDR_W: fetch address
- `if_rdata` output DATA_W: fetched instruction, registered
- `if_valid` output 1: one-cycle fetch completion pulse
- `d_req` input 1: data request, held with payload until `d_valid`
- `d_we` input 1: 1 = store, 0 = load
- `d_addr` input ADDR_W: data address
- `d_wdata` input DATA_W: store data
- `d_wstrb` input DATA_W/8: store byte enables
- `d_rdata` output DATA_W: load data, registered
- `d_valid` output 1: one-cycle data completion pulse
- `mem_req` output 1: memory request, registered
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` output 1/ADDR_W/DATA_W/DATA_W/8: latched payload; `mem_we`=0 and `mem_wstrb`=0 for fetch
- `mem_ready` input 1: memory completes the transaction this cycle; `mem_rdata` is valid
- `mem_rdata` input DATA_W: read data
- `stall_fetch` output 1: `if_req & ~if_valid`
- `stall_mem` output 1: `d_req & ~d_valid`

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE, grant decision:
  - A requester whose `*_valid` is high this cycle is ignored, because its `req` is stale.
  - `d_req` only: grant data.
  - `if_req` only: grant fetch.
  - Both present: grant data unless `streak == MAX_STREAK`, in which case grant fetch.
- On a grant:
  - Latch the payload into the `mem_*` registers.
  - Set `mem_req`=1 and enter BUSY_IF or BUSY_D.
- BUSY_x:
  - Hold `mem_req` and the payload stable until `mem_ready`.
  - On `mem_ready`, go to IDLE, clear `mem_req` and set the owner's `*_valid` for the next cycle.
  - On a read, register `mem_rdata` into the owner's `*_rdata`.
  - On a store, `d_rdata` is unchanged.
- Streak counter (saturating, 0..MAX_STREAK), updated at each IDLE grant:
  - Increment on a data grant with `if_req` pending.
  - Clear on a fetch grant.
  - Clear on a data grant with no fetch pending.
- `*_rdata` holds its value between completions.
- `mem_ready` in IDLE is ignored.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`/`mem_wdata`/`mem_wstrb`=0, `if_valid`=`d_valid`=0, `if_rdata`=`d_rdata`=0, streak=0. `stall_*` follow inputs (combinational).
- Latency: request at cycle 0 → `mem_req` at cycle 1 → `mem_ready` at cycle k≥1 → `*_valid` at k+1. Minimum 2 cycles.
- A new grant occurs at the earliest in the cycle `*_valid` is asserted, which is the IDLE cycle. Back-to-back throughput is therefore one transaction per 2 cycles minimum.
- Requests raised while BUSY wait. No request is dropped or reordered within a requester.
- Reset asserted mid-transaction: the transaction is abandoned immediately and `mem_req` drops asynchronously. No `*_valid` is issued. The memory tolerates a withdrawn request.

## Structure
- Shared package `mem_arb_pkg`:
  - state typedef (IDLE/BUSY_IF/BUSY_D)
  - owner encoding (OWN_IF=0, OWN_D=1)
- One sub-module `starve_guard`: the saturating streak counter with `grant_d`, `grant_if` and `if_pending` inputs, and an `at_limit` output.
- Everything else lives in the top module.

## Test plan
- **Single fetch:** `if_req`, `if_addr`=0x100, `mem_ready` one cycle after `mem_req`, `mem_rdata`=0x00500093 → `if_valid` pulses at cycle 3 with `if_rdata`=0x00500093; `stall_fetch` is high for cycles 0–2.
- **Simultaneous requests:** both requests in the same cycle → data granted first (`mem_addr`=d_addr). Fetch is granted in the IDLE cycle where `d_valid` pulses, and the data requester's stale `req` is not regranted.
- **Starvation guard (MAX_STREAK=4):** `d_req` continuously high with new addresses, `if_req` high → exactly 4 data grants, then 1 fetch grant, then the streak restarts.
- **Store:** `d_we`=1, `d_wstrb`=4'b0011, `d_wdata`=0xDEADBEEF → `mem_we`=1 with the payload held stable through 3 wait cycles. `d_valid` pulses and `d_rdata` is unchanged.
- **Reset mid-transaction:** `rst` asserted during BUSY_D with `mem_ready` low → `mem_req`=0 immediately, no `d_valid`, all outputs at reset values. The first request after release is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle, or busy on behalf of fetch or data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    // Which requester a grant goes to.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Bits needed to count 0..max_streak inclusive.
    function automatic int streak_width(input int max_streak);
        return $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_guard.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module starve_guard
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_d,
    input  logic grant_if,
    input  logic if_pending,
    output logic at_limit
);

    localparam int CW = streak_width(MAX_STREAK);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_STREAK);

    logic [CW-1:0] streak_q;
    logic [CW-1:0] streak_d;

    // Next streak: grow only when data overtakes a waiting fetch.
    always_comb begin
        streak_d = streak_q;
        if (grant_if) begin
            streak_d = '0;
        end else if (grant_d) begin
            if (!if_pending) begin
                streak_d = '0;
            end else if (streak_q != LIMIT) begin
                streak_d = streak_q + CW'(1);
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign at_limit = (streak_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the memory stage.
// Handshake: a requester holds req and payload until its *_valid pulse; the
// cycle that pulse is high its req is stale and never granted. mem_req and
// payload stay stable until mem_ready; mem_ready is ignored while idle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_fetch,
    output logic                stall_mem
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                if_valid_q, if_valid_d;
    logic                d_valid_q, d_valid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic   if_cand;
    logic   d_cand;
    logic   at_limit;
    logic   grant_d;
    logic   grant_if;
    owner_e grant_own;

    // A requester completing this cycle still shows its old req; skip it.
    assign if_cand = if_req & ~if_valid_q;
    assign d_cand  = d_req & ~d_valid_q;

    // Grant decision in IDLE: data first unless fetch has waited too long.
    always_comb begin
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        grant_own = OWN_IF;
        if (state_q == IDLE) begin
            if (d_cand && !(if_cand && at_limit)) begin
                grant_d   = 1'b1;
                grant_own = OWN_D;
            end else if (if_cand) begin
                grant_if  = 1'b1;
                grant_own = OWN_IF;
            end
        end
    end

    starve_guard #(
        .MAX_STREAK (MAX_STREAK)
    ) u_starve_guard (
        .clk        (clk),
        .rst        (rst),
        .grant_d    (grant_d),
        .grant_if   (grant_if),
        .if_pending (if_cand),
        .at_limit   (at_limit)
    );

    // Next-state and registered outputs: launch on grant, finish on mem_ready.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d || grant_if) begin
                    mem_req_d = 1'b1;
                    if (grant_own == OWN_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                    end else begin
                        state_d     = BUSY_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign if_valid    = if_valid_q;
    assign d_valid     = d_valid_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign stall_fetch = if_req & ~if_valid_q;
    assign stall_mem   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } d_op_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stall_fetch;
    logic        stall_mem;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_STREAK (MAXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_wstrb     (d_wstrb),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall_fetch (stall_fetch),
        .stall_mem   (stall_mem)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Memory contents seen by reads.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- requester drivers ----------------
    logic [31:0] if_q[$];
    d_op_t       d_q[$];
    bit          if_active = 0, if_done = 0;
    bit          d_active  = 0, d_done  = 0;
    bit          if_hide   = 0;  // withdraw fetch during data completions
    d_op_t       cur_op;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            if_active = 0; if_done = 0; d_active = 0; d_done = 0;
            if_req = 1'b0; d_req = 1'b0;
        end else begin
            if (if_done) begin
                if_done = 0; if_active = 0;
            end else if (if_active && if_valid) begin
                if_done = 1;
            end
            if (!if_active && if_q.size() > 0) begin
                if_addr = if_q.pop_front();
                if_active = 1;
            end
            if_req = if_active && !(if_hide && d_valid);

            if (d_done) begin
                d_done = 0; d_active = 0;
            end else if (d_active && d_valid) begin
                d_done = 1;
            end
            if (!d_active && d_q.size() > 0) begin
                cur_op  = d_q.pop_front();
                d_we    = cur_op.we;
                d_addr  = cur_op.addr;
                d_wdata = cur_op.wdata;
                d_wstrb = cur_op.wstrb;
                d_active = 1;
            end
            d_req = d_active;
        end
    end

    // ---------------- memory responder ----------------
    int wait_n    = 1;  // cycles mem_req is high before mem_ready
    bit idle_poke = 0;  // spurious mem_ready while idle
    int busy_cnt  = 0;

    always @(posedge clk) begin
        #1;
        if (mem_req) busy_cnt++;
        else busy_cnt = 0;
        mem_ready = mem_req ? (busy_cnt > wait_n) : idle_poke;
        mem_rdata = mem_word(mem_addr);
    end

    // ---------------- reference model ----------------
    int          m_owner    = 0;  // 0 none, 1 fetch, 2 data
    int          m_streak   = 0;
    logic        e_mem_req  = 1'b0;
    logic        e_we       = 1'b0;
    logic [31:0] e_addr     = '0;
    logic [31:0] e_wdata    = '0;
    logic [3:0]  e_wstrb    = '0;
    logic        e_if_valid = 1'b0;
    logic        e_d_valid  = 1'b0;
    logic [31:0] e_if_rdata = '0;
    logic [31:0] e_d_rdata  = '0;
    logic [31:0] model_log[$];

    always @(posedge clk or posedge rst) begin
        bit ifc, dc, nv_if, nv_d;
        if (rst) begin
            m_owner = 0; m_streak = 0;
            e_mem_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
            e_if_valid = 0; e_d_valid = 0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            nv_if = 0;
            nv_d  = 0;
            if (m_owner == 0) begin
                ifc = if_req && !e_if_valid;
                dc  = d_req && !e_d_valid;
                if (dc && !(ifc && m_streak == MAXS)) begin
                    m_owner = 2; e_mem_req = 1;
                    e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb;
                    m_streak = ifc ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                    model_log.push_back(d_addr);
                end else if (ifc) begin
                    m_owner = 1; e_mem_req = 1;
                    e_we = 0; e_addr = if_addr; e_wdata = '0; e_wstrb = '0;
                    m_streak = 0;
                    model_log.push_back(if_addr);
                end
            end else if (mem_ready) begin
                if (m_owner == 1) begin
                    e_if_rdata = mem_word(e_addr);
                    nv_if = 1;
                end else begin
                    if (!e_we) e_d_rdata = mem_word(e_addr);
                    nv_d = 1;
                end
                m_owner = 0;
                e_mem_req = 0;
            end
            e_if_valid = nv_if;
            e_d_valid  = nv_d;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("mem_req",     mem_req,     e_mem_req);
        check("mem_we",      mem_we,      e_we);
        check("mem_addr",    mem_addr,    e_addr);
        check("mem_wdata",   mem_wdata,   e_wdata);
        check("mem_wstrb",   mem_wstrb,   e_wstrb);
        check("if_valid",    if_valid,    e_if_valid);
        check("d_valid",     d_valid,     e_d_valid);
        check("if_rdata",    if_rdata,    e_if_rdata);
        check("d_rdata",     d_rdata,     e_d_rdata);
        check("stall_fetch", stall_fetch, if_req & ~e_if_valid);
        check("stall_mem",   stall_mem,   d_req & ~e_d_valid);
    end

    // DUT grant log: address of every rising mem_req.
    logic [31:0] dut_log[$];
    logic        prev_req = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !prev_req) dut_log.push_back(mem_addr);
        prev_req = mem_req;
    end

    // ---------------- helpers ----------------
    task automatic drain(input string name, input int max_cycles);
        bit done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            done = (if_q.size() == 0) && (d_q.size() == 0) && !if_active && !d_active;
        end
        check(name, done, 1);
    endtask

    logic [31:0] exp_q[$];

    task automatic check_grants(input string name, input int dbase, input int mbase);
        check({name, "_dut_count"}, dut_log.size() - dbase, exp_q.size());
        check({name, "_model_count"}, model_log.size() - mbase, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (dbase + i < dut_log.size())   check({name, "_dut"},   dut_log[dbase + i],   exp_q[i]);
            if (mbase + i < model_log.size()) check({name, "_model"}, model_log[mbase + i], exp_q[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int db, mb;
        bit seen;

        repeat (3) @(negedge clk);
        check("reset_mem_req",  mem_req,  1'b0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_if_valid", if_valid, 1'b0);
        check("reset_d_rdata",  d_rdata,  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single fetch: ready one cycle after mem_req, valid at cycle 3.
        wait_n = 1;
        if_q.push_back(32'h100);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 2) check("t1_stall_fetch", stall_fetch, 1'b1);
            if (c == 1) check("t1_mem_addr", mem_addr, 32'h100);
            if (c == 1) check("t1_mem_req", mem_req, 1'b1);
            if (c == 3) check("t1_if_valid", if_valid, 1'b1);
            if (c == 3) check("t1_if_rdata", if_rdata, 32'h00500093);
            if (c == 4) check("t1_if_valid_drop", if_valid, 1'b0);
            if (c == 4) check("t1_if_rdata_hold", if_rdata, 32'h00500093);
        end
        drain("t1_drain", 20);

        // Simultaneous requests: data first, then fetch in the d_valid cycle.
        db = dut_log.size();
        mb = model_log.size();
        if_q.push_back(32'h104);
        d_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) check("t2_mem_addr_d", mem_addr, 32'h300);
            if (c == 3) check("t2_d_valid", d_valid, 1'b1);
            if (c == 3) check("t2_d_rdata", d_rdata, 32'h0300FCFF);
            if (c == 4) check("t2_mem_req_if", mem_req, 1'b1);
            if (c == 4) check("t2_mem_addr_if", mem_addr, 32'h104);
            if (c == 6) check("t2_if_valid", if_valid, 1'b1);
            if (c == 6) check("t2_if_rdata", if_rdata, 32'h0104FEFB);
        end
        drain("t2_drain", 20);
        exp_q = '{32'h300, 32'h104};
        check_grants("t2_grants", db, mb);

        // Stray mem_ready while idle is ignored.
        idle_poke = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_poke_mem_req", mem_req, 1'b0);
            check("idle_poke_d_valid", d_valid, 1'b0);
        end
        idle_poke = 0;
        @(negedge clk);

        // Store held through 3 wait cycles; d_rdata keeps the last load.
        wait_n = 3;
        d_q.push_back('{1'b1, 32'h400, 32'hDEADBEEF, 4'b0011});
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4) begin
                check("t3_mem_req",   mem_req,   1'b1);
                check("t3_mem_we",    mem_we,    1'b1);
                check("t3_mem_addr",  mem_addr,  32'h400);
                check("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
                check("t3_mem_wstrb", mem_wstrb, 4'b0011);
            end
            if (c == 5) check("t3_d_valid", d_valid, 1'b1);
            if (c == 5) check("t3_d_rdata", d_rdata, 32'h0300FCFF);
        end
        drain("t3_drain", 20);

        // Starvation guard: fetch steps aside during data completions so the
        // data side keeps winning; after 4 data grants fetch must get in.
        wait_n = 1;
        if_hide = 1;
        db = dut_log.size();
        mb = model_log.size();
        if_q.push_back(32'h108);
        for (int i = 0; i < 7; i++) d_q.push_back('{1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'h0});
        drain("t4_drain", 200);
        if_hide = 0;
        exp_q = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h108, 32'h210, 32'h214, 32'h218};
        check_grants("t4_grants", db, mb);
        check("t4_d_rdata", d_rdata, 32'h0218FDE7);

        // Reset in the middle of a data transaction.
        wait_n = 5;
        d_q.push_back('{1'b0, 32'h500, 32'h0, 4'h0});
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        check("t5_granted", seen, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_mem_req",  mem_req,  1'b0);
        check("t5_async_mem_addr", mem_addr, 32'h0);
        check("t5_async_d_rdata",  d_rdata,  32'h0);
        check("t5_async_if_rdata", if_rdata, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_d_valid", d_valid, 1'b0);
        db = dut_log.size();
        mb = model_log.size();
        wait_n = 1;
        d_q.push_back('{1'b0, 32'h504, 32'h0, 4'h0});
        drain("t5_drain", 20);
        exp_q = '{32'h504};
        check_grants("t5_grants", db, mb);
        check("t5_d_rdata", d_rdata, 32'h0504FAFB);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop if something never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout @%0t: got running, expected finished", $time);
        $fatal(1, "timeout");
    end

endmodule
